// File: rtl/cmd_tx_scheduler_pkg.sv
// cmd_tx_scheduler_pkg: shared FSM encoding, default command base and UART handshake helpers
package cmd_tx_scheduler_pkg;

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_SEND      = 2'd1,
        S_WAIT_DONE = 2'd2,
        S_GAP       = 2'd3
    } state_e;

    localparam logic [7:0] CMD_BASE_DEFAULT = 8'h41;

    // A byte is handed to the UART on the cycle where valid and ready are both high.
    function automatic logic tx_accept(input logic valid, input logic ready);
        return valid & ready;
    endfunction

    // Requester i sends base + i, wrapping modulo 256.
    function automatic logic [7:0] cmd_byte(input logic [7:0] base, input logic [2:0] idx);
        return base + {5'b0, idx};
    endfunction

endpackage

// File: rtl/cmd_tx_scheduler_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first pending index at or above ptr, wrapping
module rr_arbiter #(
    parameter int N  = 4,
    parameter int IW = 3
) (
    input  logic [N-1:0]  pending_i,
    input  logic [IW-1:0] ptr_i,
    output logic          grant_valid_o,
    output logic [IW-1:0] grant_idx_o
);

    // Scan offsets from farthest to nearest so the nearest pending index wins.
    always_comb begin
        int j;
        j = 0;
        grant_valid_o = 1'b0;
        grant_idx_o = '0;
        for (int k = N - 1; k >= 0; k--) begin
            j = (int'(ptr_i) + k) % N;
            if (pending_i[j]) begin
                grant_valid_o = 1'b1;
                grant_idx_o = IW'(j);
            end
        end
    end

endmodule

// File: rtl/cmd_tx_scheduler.sv
// cmd_tx_scheduler: latches request pulses, arbitrates round-robin and paces command bytes to a UART
module cmd_tx_scheduler
    import cmd_tx_scheduler_pkg::*;
#(
    parameter int         N_REQ      = 4,
    parameter int         GAP_CYCLES = 1000,
    parameter logic [7:0] CMD_BASE   = CMD_BASE_DEFAULT
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [N_REQ-1:0] req_pulse,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready,
    input  logic             tx_done,
    output logic [N_REQ-1:0] pending,
    output logic             busy,
    output logic [7:0]       drop_cnt,
    output logic [2:0]       last_idx
);

    localparam logic [15:0] GAP_LOAD = 16'(GAP_CYCLES - 1);

    state_e           state_q, state_d;
    logic [2:0]       ptr_q, ptr_d;
    logic [2:0]       last_q, last_d;
    logic [7:0]       data_q, data_d;
    logic [7:0]       drop_q, drop_d;
    logic [15:0]      gap_q, gap_d;
    logic [N_REQ-1:0] pending_q, pending_d;
    logic [N_REQ-1:0] clr, drops;
    logic [3:0]       hits;
    logic [8:0]       drop_sum;
    logic             grant_valid, grant;
    logic [2:0]       grant_idx;

    rr_arbiter #(.N(N_REQ), .IW(3)) u_arb (
        .pending_i    (pending_q),
        .ptr_i        (ptr_q),
        .grant_valid_o(grant_valid),
        .grant_idx_o  (grant_idx)
    );

    assign grant    = (state_q == S_IDLE) && enable && grant_valid;
    assign tx_valid = (state_q == S_SEND);
    assign busy     = (state_q != S_IDLE);
    assign tx_data  = data_q;
    assign pending  = pending_q;
    assign drop_cnt = drop_q;
    assign last_idx = last_q;

    // Pending set/clear (a new pulse beats a same-edge grant) and saturating drop count.
    always_comb begin
        clr = grant ? N_REQ'(1) << grant_idx : '0;
        drops = req_pulse & pending_q & ~clr;
        pending_d = (pending_q & ~clr) | req_pulse;
        hits = '0;
        for (int i = 0; i < N_REQ; i++) hits = hits + {3'b0, drops[i]};
        drop_sum = {1'b0, drop_q} + {5'b0, hits};
        drop_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];
    end

    // Transmit sequencing: grant, offer byte, await done, then hold off for the idle gap.
    always_comb begin
        state_d = state_q;
        ptr_d = ptr_q;
        last_d = last_q;
        data_d = data_q;
        gap_d = gap_q;
        case (state_q)
            S_IDLE: if (grant) begin
                state_d = S_SEND;
                data_d = cmd_byte(CMD_BASE, grant_idx);
                last_d = grant_idx;
                ptr_d = (grant_idx == 3'(N_REQ - 1)) ? 3'd0 : grant_idx + 3'd1;
            end
            S_SEND: if (tx_accept(tx_valid, tx_ready)) begin
                state_d = tx_done ? S_GAP : S_WAIT_DONE;
                gap_d = GAP_LOAD;
            end
            S_WAIT_DONE: if (tx_done) begin
                state_d = S_GAP;
                gap_d = GAP_LOAD;
            end
            S_GAP: begin
                state_d = (gap_q == 16'd0) ? S_IDLE : S_GAP;
                gap_d = (gap_q == 16'd0) ? 16'd0 : gap_q - 16'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and datapath registers; reset discards everything in flight.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            ptr_q <= '0;
            last_q <= '0;
            data_q <= '0;
            drop_q <= '0;
            gap_q <= '0;
            pending_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q <= ptr_d;
            last_q <= last_d;
            data_q <= data_d;
            drop_q <= drop_d;
            gap_q <= gap_d;
            pending_q <= pending_d;
        end
    end

endmodule

// File: doc/cmd_tx_scheduler.md
Name: cmd_tx_scheduler

Overview:
- Collects single-cycle button/event pulses from the edge detectors on the master FPGA and converts each into one command byte for the Bluetooth UART transmitter.
- Holds every request as pending, arbitrates round-robin when several are pending, and sequences the transmitter through a valid/ready/done handshake.
- Enforces a minimum idle gap between consecutive commands so the remote car's receiver is not overrun.

Parameters:
- N_REQ, 4, number of requesters; supported range 2..8.
- GAP_CYCLES, 1000, idle clocks after tx_done before the next tx_valid; supported range 1..65535.
- CMD_BASE, 8'h41, command byte for requester 0; requester i sends CMD_BASE+i, computed modulo 256.

Ports:
- clock  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- enable  in  1  when low, no new grants are made; pulses are still latched
- req_pulse  in  N_REQ  one-cycle request pulses, one bit per requester
- tx_data  out  8  command byte; stable while tx_valid is high
- tx_valid  out  1  command offered to the UART transmitter
- tx_ready  in  1  transmitter accepts the byte when tx_valid and tx_ready are both high
- tx_done  in  1  one-cycle pulse when the byte has finished shifting out
- pending  out  N_REQ  latched, unserved requests
- busy  out  1  high in every state except IDLE
- drop_cnt  out  8  saturating count of pulses that arrived while their bit was already pending
- last_idx  out  3  index of the most recent grant

Behaviour:
- Reset (asynchronous, reset_n low): all outputs are 0, the FSM is in IDLE, and the round-robin pointer is 0.
- Pending set and clear:
  - pending[i] sets on the clock edge after req_pulse[i]=1.
  - pending[i] clears on the grant edge for requester i.
  - If a set and a clear hit the same bit on the same edge, set wins; the bit stays pending and no drop is counted.
  - A pulse on a bit that is already pending and not being cleared increments drop_cnt, saturating at 255.
- Arbitration (in IDLE only, when enable=1 and pending != 0):
  - Grant the first pending index searching upward from ptr, wrapping.
  - On the grant edge: ptr becomes (granted index + 1) mod N_REQ, last_idx becomes the granted index, and tx_data becomes CMD_BASE + index.
- FSM states: IDLE, SEND, WAIT_DONE, GAP.
  - IDLE -> SEND on grant. tx_valid rises on the grant edge, so it is high 1 cycle after pending becomes visible.
  - SEND: hold tx_valid and tx_data until tx_ready=1. On that edge tx_valid drops and the FSM moves to WAIT_DONE.
  - WAIT_DONE: wait for tx_done, then load the gap counter with GAP_CYCLES-1 and move to GAP.
  - A tx_done that arrives in the same cycle as the accepting tx_ready counts. The FSM goes directly SEND -> GAP.
  - GAP: decrement the counter each cycle. At 0, move to IDLE.
  - A new grant can be made on the IDLE cycle that follows the gap.
  - Result: the earliest next tx_valid comes GAP_CYCLES+1 cycles after the tx_done edge.
- enable:
  - Deasserting enable mid-transaction does not abort it; the current byte and its gap complete.
  - Pulses that arrive while enable=0 are still latched.
- tx_done outside WAIT_DONE (or the SEND accept cycle) is ignored.
- Reset mid-operation: pending, drop_cnt and the in-flight command are discarded immediately; tx_valid drops asynchronously.
- Width rules:
  - The gap counter is 16 bits.
  - last_idx is zero-extended to 3 bits.

Decomposition:
- Shared package holds:
  - FSM state encoding (S_IDLE, S_SEND, S_WAIT_DONE, S_GAP)
  - default CMD_BASE
  - the UART handshake convention
- One sub-module, rr_arbiter: a combinational round-robin priority pick taking pending and ptr and returning grant_valid and grant_idx. It is reusable by the slave FPGA's sensor-report path.
- The FSM, pending register and counters stay in the top module.

Test Plan:
- Single request: req_pulse=4'b0100 for 1 cycle -> tx_valid rises 1 cycle later with tx_data=8'h43. Tie tx_ready=1 and pulse tx_done 10 cycles after accept -> busy stays high for GAP_CYCLES cycles more, then pending=0 and last_idx=2.
- Simultaneous requests: req_pulse=4'b1111 at ptr=0 -> bytes 8'h41, 8'h42, 8'h43, 8'h44 in that order. Each tx_valid comes exactly GAP_CYCLES+1 cycles after the previous tx_done.
- Fairness and wrap: after requester 3 is served, pulse bits 0 and 3 together -> 8'h41 is sent before 8'h44.
- Drops: three pulses on bit 1 while it is pending and the FSM is in GAP -> drop_cnt=3, and only one 8'h42 is sent. Then 300 repeated pulses -> drop_cnt saturates at 255.
- Backpressure and same-cycle done: hold tx_ready=0 for 50 cycles -> tx_valid and tx_data stay stable. Then assert tx_ready and tx_done in the same cycle -> FSM goes directly to GAP.
- Enable and reset: with enable=0, pulse bit 0 -> pending=4'b0001 and no tx_valid. Raise enable -> 8'h41 is sent. Drop reset_n during SEND -> tx_valid=0 immediately and every output is 0.
